// File: rtl/instr_fetch_buf.sv
// Instruction fetch front-end: issues word reads to the instruction bus, buffers
// returned words with their PCs in a small FIFO, and hands them to decode.
module instr_fetch_buf #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        bus_rd_req,
   output logic [31:0] bus_rd_addr,
   input  logic        bus_rd_gnt,
   input  logic [31:0] bus_rd_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   localparam int CW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          drop_q, drop_d;
   logic [CW:0]   count_q, count_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];

   logic          grant;
   logic          push;
   logic          pop;
   logic [CW:0]   occ;

   // Credit check counts the in-flight word so every granted read has a slot.
   always_comb begin
      occ         = count_q + {{CW{1'b0}}, inflight_q};
      bus_rd_req  = !rst && !redirect_valid && (occ < DEPTH_C);
      bus_rd_addr = fetch_pc_q;
      out_valid   = !rst && (count_q != '0);
      out_pc      = pc_mem[rd_ptr_q];
      out_instr   = instr_mem[rd_ptr_q];
      grant       = bus_rd_req && bus_rd_gnt;
      push        = inflight_q && !drop_q && !redirect_valid;
      pop         = out_valid && out_ready && !redirect_valid;
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      drop_d        = drop_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         drop_d     = 1'b0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (grant) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
         drop_q        <= 1'b0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         pc_mem[wr_ptr_q]    <= inflight_pc_q;
         instr_mem[wr_ptr_q] <= bus_rd_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_buf.sv
// Bench for instr_fetch_buf: directed scenarios plus random traffic, checked
// against a queue-based model of the fetch buffer.
module tb_instr_fetch_buf;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        bus_rd_req;
   logic [31:0] bus_rd_addr;
   logic        bus_rd_gnt;
   logic [31:0] bus_rd_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   instr_fetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus_rd_req     (bus_rd_req),
      .bus_rd_addr    (bus_rd_addr),
      .bus_rd_gnt     (bus_rd_gnt),
      .bus_rd_data    (bus_rd_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int grants = 0;

   // Model: queue of buffered PCs plus the next fetch address and in-flight read.
   logic [31:0] mq[$];
   logic [31:0] m_fetch = RESET_PC;
   logic [31:0] m_inflight_pc = '0;
   int          m_inflight = 0;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic do_cycle(input logic r, input logic g, input logic rdy,
                           input logic rv, input logic [31:0] rpc);
      logic        exp_req;
      logic        rom_hit;
      logic [31:0] rom_addr;
      logic [31:0] head;
      rst = r; bus_rd_gnt = g; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      #1;
      exp_req = !r && !rv && ((mq.size() + m_inflight) < DEPTH);
      check_eq("req", {31'd0, bus_rd_req}, {31'd0, exp_req});
      if (exp_req) check_eq("addr", bus_rd_addr, m_fetch);
      check_eq("valid", {31'd0, out_valid}, {31'd0, (!r && mq.size() != 0)});
      if (!r && mq.size() != 0) begin
         head = mq[0];
         check_eq("out_pc", out_pc, head);
         check_eq("out_instr", out_instr, rom_word(head));
      end
      rom_hit  = bus_rd_req && g;
      rom_addr = bus_rd_addr;
      if (rom_hit) grants++;
      @(posedge clk);
      if (r) begin
         mq.delete(); m_fetch = RESET_PC; m_inflight = 0;
      end else if (rv) begin
         mq.delete(); m_fetch = {rpc[31:2], 2'b00}; m_inflight = 0;
      end else begin
         if (rdy && mq.size() != 0) void'(mq.pop_front());
         if (m_inflight != 0) mq.push_back(m_inflight_pc);
         if (exp_req && g) begin
            m_inflight = 1; m_inflight_pc = m_fetch; m_fetch = m_fetch + 32'd4;
         end else begin
            m_inflight = 0;
         end
      end
      #1;
      bus_rd_data = rom_hit ? rom_word(rom_addr) : $urandom;
      @(negedge clk);
   endtask

   initial begin
      int reached;
      rst = 1'b1; bus_rd_gnt = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; bus_rd_data = '0;
      @(negedge clk);

      // Reset, then free-run with immediate grants and a ready consumer.
      repeat (3) do_cycle(1, 1, 1, 0, 0);
      repeat (20) do_cycle(0, 1, 1, 0, 0);

      // Backpressure from a fresh reset: exactly DEPTH grants, then drain in order.
      repeat (2) do_cycle(1, 1, 0, 0, 0);
      grants = 0;
      repeat (10) do_cycle(0, 1, 0, 0, 0);
      check_eq("bp_grants", grants, DEPTH);
      repeat (8) do_cycle(0, 1, 1, 0, 0);

      // Redirect while a word is in flight and three entries are buffered.
      repeat (2) do_cycle(1, 1, 0, 0, 0);
      reached = 0;
      for (int i = 0; i < 10 && reached == 0; i++) begin
         if (mq.size() == 3 && m_inflight == 1) reached = 1;
         else do_cycle(0, 1, 0, 0, 0);
      end
      check_eq("redir_setup", reached, 1);
      do_cycle(0, 1, 1, 1, 32'h0000_0040);
      repeat (10) do_cycle(0, 1, 1, 0, 0);

      // Grant stall: request and address must hold.
      repeat (5) do_cycle(0, 0, 1, 0, 0);
      repeat (6) do_cycle(0, 1, 1, 0, 0);

      // Misaligned redirect near the top of the address space wraps to zero.
      do_cycle(0, 1, 1, 1, 32'hFFFF_FFFE);
      repeat (8) do_cycle(0, 1, 1, 0, 0);

      // Reset with a response pending.
      repeat (3) do_cycle(0, 1, 0, 0, 0);
      do_cycle(1, 1, 1, 0, 0);
      repeat (6) do_cycle(0, 1, 1, 0, 0);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         do_cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 19) == 0),
                  $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
